qoi_buf_ctrl: RTL and testbench

- Ping-pong input-buffer controller for the QOI accelerator; owns two BANK_BYTES-deep byte banks of the shared buffer memory.
- The CPU fills one bank through its own memory path, then commits it with a byte count. The accelerator drains the other bank byte-by-byte through a request/valid handshake.
- On drain completion the bank returns to the CPU with an interrupt. The block drives bank select and read address only; data bytes never pass through it.

---
 rtl/qoi_buf_ctrl_pkg.sv | 27 ++
 rtl/qoi_buf_ctrl.sv | 153 +++++++++++++++
 tb/tb_qoi_buf_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_buf_ctrl_pkg.sv
// rtl/qoi_buf_ctrl_pkg.sv - register map, bit positions and FSM states for qoi_buf_ctrl
package qoi_types;

    localparam logic [1:0] QBC_LEN_LO = 2'd0;
    localparam logic [1:0] QBC_LEN_HI = 2'd1;
    localparam logic [1:0] QBC_CTRL   = 2'd2;
    localparam logic [1:0] QBC_STATUS = 2'd3;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_IRQ_CLR = 2;

    localparam int ST_FULL0    = 0;
    localparam int ST_FULL1    = 1;
    localparam int ST_CPU_BANK = 2;
    localparam int ST_ACC_BANK = 3;
    localparam int ST_BUSY     = 4;
    localparam int ST_IRQ      = 5;
    localparam int ST_ERR      = 7;

    typedef enum logic [1:0] {
        BC_IDLE,
        BC_ACTIVE,
        BC_RELEASE
    } bc_state_t;

endpackage

// File: rtl/qoi_buf_ctrl.sv
// rtl/qoi_buf_ctrl.sv - ping-pong input-buffer controller: CPU register file plus drain FSM
module qoi_buf_ctrl
    import qoi_types::*;
#(
    parameter int BANK_BYTES = 256,
    parameter int LEN_W      = $clog2(BANK_BYTES) + 1,
    localparam int AW        = $clog2(BANK_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [1:0]    addr,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    output logic          cpu_bank_o,
    input  logic          acc_req_i,
    output logic          acc_rd_o,
    output logic          acc_bank_o,
    output logic [AW-1:0] acc_addr_o,
    output logic          acc_valid_o,
    output logic          acc_empty_o,
    output logic          irq_o
);

    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len [2];
    logic [LEN_W-1:0] remaining;
    logic [1:0]       full;
    logic             cpu_bank;
    logic             acc_bank;
    logic             irq;
    logic             err;
    logic [AW-1:0]    ptr;
    bc_state_t        state;

    logic        wr;
    logic        do_abort;
    logic        do_commit;
    logic        do_irq_clr;
    logic        commit_bad;
    logic [15:0] len_wide;
    logic [15:0] len_lo_wr;
    logic [15:0] len_hi_wr;

    always_comb begin
        wr         = cs & we;
        do_abort   = wr && (addr == QBC_CTRL) && data_i[CTRL_ABORT];
        do_commit  = wr && (addr == QBC_CTRL) && data_i[CTRL_COMMIT] && !data_i[CTRL_ABORT];
        do_irq_clr = wr && (addr == QBC_CTRL) && data_i[CTRL_IRQ_CLR];
        // full is sampled before any same-cycle release, so committing into the bank being freed fails
        commit_bad = (len_reg == '0) || (len_reg > LEN_W'(BANK_BYTES)) || full[cpu_bank];
        len_wide   = 16'(len_reg);
        len_lo_wr  = {len_wide[15:8], data_i};
        len_hi_wr  = {data_i, len_wide[7:0]};
    end

    always_comb begin
        acc_rd_o    = (state == BC_ACTIVE) && acc_req_i && (remaining != '0);
        acc_addr_o  = ptr;
        acc_bank_o  = acc_bank;
        cpu_bank_o  = cpu_bank;
        acc_empty_o = (state == BC_IDLE) && !full[acc_bank];
        irq_o       = irq;
    end

    always_comb begin
        data_o = 8'h00;
        if (cs) begin
            case (addr)
                QBC_LEN_LO: data_o = len_wide[7:0];
                QBC_LEN_HI: data_o = len_wide[15:8];
                QBC_STATUS: data_o = {err, 1'b0, irq, state != BC_IDLE,
                                      acc_bank, cpu_bank, full[1], full[0]};
                default:    data_o = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg     <= '0;
            len[0]      <= '0;
            len[1]      <= '0;
            remaining   <= '0;
            full        <= 2'b00;
            cpu_bank    <= 1'b0;
            acc_bank    <= 1'b0;
            irq         <= 1'b0;
            err         <= 1'b0;
            ptr         <= '0;
            acc_valid_o <= 1'b0;
            state       <= BC_IDLE;
        end else begin
            acc_valid_o <= 1'b0;

            if (wr && addr == QBC_LEN_LO) len_reg <= len_lo_wr[LEN_W-1:0];
            if (wr && addr == QBC_LEN_HI) len_reg <= len_hi_wr[LEN_W-1:0];
            if (do_irq_clr) irq <= 1'b0;

            if (do_abort) begin
                // soft reset: len_reg and irq survive; any in-flight valid is dropped above
                len[0]    <= '0;
                len[1]    <= '0;
                remaining <= '0;
                full      <= 2'b00;
                cpu_bank  <= 1'b0;
                acc_bank  <= 1'b0;
                err       <= 1'b0;
                ptr       <= '0;
                state     <= BC_IDLE;
            end else begin
                if (wr && addr == QBC_STATUS) err <= 1'b0;

                case (state)
                    BC_IDLE: begin
                        if (full[acc_bank]) begin
                            ptr       <= '0;
                            remaining <= len[acc_bank];
                            state     <= BC_ACTIVE;
                        end
                    end
                    BC_ACTIVE: begin
                        if (acc_rd_o) begin
                            ptr         <= ptr + AW'(1);
                            remaining   <= remaining - LEN_W'(1);
                            acc_valid_o <= 1'b1;
                            if (remaining == LEN_W'(1)) state <= BC_RELEASE;
                        end
                    end
                    BC_RELEASE: begin
                        full[acc_bank] <= 1'b0;
                        acc_bank       <= ~acc_bank;
                        irq            <= 1'b1;
                        state          <= BC_IDLE;
                    end
                    default: state <= BC_IDLE;
                endcase

                if (do_commit) begin
                    if (commit_bad) begin
                        err <= 1'b1;
                    end else begin
                        len[cpu_bank]  <= len_reg;
                        full[cpu_bank] <= 1'b1;
                        cpu_bank       <= ~cpu_bank;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_qoi_buf_ctrl.sv
// tb/tb_qoi_buf_ctrl.sv - randomized self-checking bench for qoi_buf_ctrl
module tb_qoi_buf_ctrl;
    import qoi_types::*;

    localparam int BB = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          we;
    logic [1:0]    addr;
    logic [7:0]    data_i;
    logic [7:0]    data_o;
    logic          cpu_bank_o;
    logic          acc_req_i;
    logic          acc_rd_o;
    logic          acc_bank_o;
    logic [AW-1:0] acc_addr_o;
    logic          acc_valid_o;
    logic          acc_empty_o;
    logic          irq_o;

    qoi_buf_ctrl #(.BANK_BYTES(BB)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_i(data_i),
        .data_o(data_o), .cpu_bank_o(cpu_bank_o), .acc_req_i(acc_req_i),
        .acc_rd_o(acc_rd_o), .acc_bank_o(acc_bank_o), .acc_addr_o(acc_addr_o),
        .acc_valid_o(acc_valid_o), .acc_empty_o(acc_empty_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] m_full;
    int         m_len [2];
    logic       m_cpu, m_acc, m_irq, m_err;
    int         m_len_reg;

    function automatic logic [7:0] exp_status();
        return {m_err, 1'b0, m_irq, m_full != 2'b00, m_acc, m_cpu, m_full[1], m_full[0]};
    endfunction

    task automatic model_reset();
        m_full = 2'b00; m_len[0] = 0; m_len[1] = 0;
        m_cpu = 0; m_acc = 0; m_irq = 0; m_err = 0; m_len_reg = 0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1; we = 1; addr = a; data_i = d;
        @(posedge clk); #1;
        cs = 0; we = 0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        cs = 1; we = 0; addr = a;
        #1 d = data_o;
        cs = 0;
    endtask

    task automatic set_len(input int n);
        logic [15:0] v;
        v = 16'(n);
        reg_write(QBC_LEN_LO, v[7:0]);
        reg_write(QBC_LEN_HI, v[15:8]);
        m_len_reg = n & 'h1FF;
    endtask

    task automatic commit();
        reg_write(QBC_CTRL, 8'h01);
        if (m_len_reg == 0 || m_len_reg > BB || m_full[m_cpu]) m_err = 1;
        else begin
            m_len[m_cpu] = m_len_reg;
            m_full[m_cpu] = 1;
            m_cpu = ~m_cpu;
        end
    endtask

    task automatic check_status(input string name);
        logic [7:0] s;
        reg_read(QBC_STATUS, s);
        n_checks++;
        if (s !== exp_status()) begin
            n_fail++;
            $display("FAIL %s: STATUS got %02h expected %02h", name, s, exp_status());
        end
    endtask

    // mode 0: req held high, 1: req toggles starting high, 2: random req
    task automatic run_drain(input int mode, input bit from_commit);
        int eb[$]; int ea[$]; bit ef[$];
        int cyc, last, first, total, ndrained, b;
        logic prev_rd, req;
        ndrained = 0;
        for (int k = 0; k < 2; k++) begin
            b = int'(m_acc) ^ k;
            if (!m_full[b]) break;
            for (int i = 0; i < m_len[b]; i++) begin
                eb.push_back(b); ea.push_back(i); ef.push_back(i == 0 && k == 1);
            end
            ndrained++;
        end
        total = eb.size(); cyc = 0; last = -1; first = -1; prev_rd = 0;
        while (eb.size() > 0 && cyc < 4 * total + 20) begin
            case (mode)
                0:       req = 1'b1;
                1:       req = (cyc % 2 == 0);
                default: req = 1'($urandom_range(0, 1));
            endcase
            acc_req_i = req;
            #1;
            n_checks++;
            if (acc_valid_o !== prev_rd) begin
                n_fail++;
                $display("FAIL valid_lag: cycle %0d valid %b expected %b", cyc, acc_valid_o, prev_rd);
            end
            if (acc_rd_o === 1'b1) begin
                n_checks++;
                if (!req) begin
                    n_fail++;
                    $display("FAIL rd_without_req: cycle %0d strobe 1 expected 0", cyc);
                end
                n_checks++;
                if (int'(acc_bank_o) !== eb[0] || int'(acc_addr_o) !== ea[0]) begin
                    n_fail++;
                    $display("FAIL rd_addr: got bank %0d addr %0d expected bank %0d addr %0d",
                             acc_bank_o, acc_addr_o, eb[0], ea[0]);
                end
                if (ef[0] && mode == 0) begin
                    n_checks++;
                    if (cyc - last !== 3) begin
                        n_fail++;
                        $display("FAIL bank_gap: got %0d cycles expected 3", cyc - last);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                void'(eb.pop_front()); void'(ea.pop_front()); void'(ef.pop_front());
            end
            prev_rd = acc_rd_o;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (eb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d strobes missing expected 0", eb.size());
        end
        if (from_commit && mode == 0) begin
            n_checks++;
            if (first !== 1) begin
                n_fail++;
                $display("FAIL first_latency: got cycle %0d expected 1", first);
            end
        end
        if (from_commit && mode == 1) begin
            n_checks++;
            if (first !== 2 || last !== 2 * total) begin
                n_fail++;
                $display("FAIL toggle_timing: first %0d last %0d expected 2 and %0d", first, last, 2 * total);
            end
        end
        acc_req_i = 1;
        #1;
        n_checks++;
        if (acc_valid_o !== prev_rd || acc_rd_o !== 1'b0) begin
            n_fail++;
            $display("FAIL release_cycle: valid %b rd %b expected %b 0", acc_valid_o, acc_rd_o, prev_rd);
        end
        @(posedge clk); #1;
        for (int k = 0; k < ndrained; k++) begin
            m_full[m_acc] = 0; m_acc = ~m_acc; m_irq = 1;
        end
        n_checks++;
        if (acc_rd_o !== 1'b0 || irq_o !== 1'b1 || acc_empty_o !== 1'b1 || acc_bank_o !== m_acc) begin
            n_fail++;
            $display("FAIL after_drain: rd %b irq %b empty %b bank %b expected 0 1 1 %b",
                     acc_rd_o, irq_o, acc_empty_o, acc_bank_o, m_acc);
        end
        acc_req_i = 0;
        check_status("status_after_drain");
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1; cs = 0; we = 0; addr = 0; data_i = 0; acc_req_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_status("reset_status");
        n_checks++;
        if (acc_empty_o !== 1'b1 || irq_o !== 1'b0 || cpu_bank_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: empty %b irq %b cpu_bank %b expected 1 0 0", acc_empty_o, irq_o, cpu_bank_o);
        end
        reg_read(QBC_LEN_LO, v);
        n_checks++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_len: got %02h expected 00", v);
        end
    endtask

    task automatic test_single();
        set_len(4);
        commit();
        run_drain(0, 1);
        n_checks++;
        if (cpu_bank_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cpu_bank: got %b expected 1", cpu_bank_o);
        end
    endtask

    task automatic test_back_to_back();
        set_len(2); commit();
        set_len(3); commit();
        commit();
        @(posedge clk); #1;
        check_status("third_commit_rejected");
        run_drain(0, 0);
        reg_write(QBC_STATUS, 8'h00);
        m_err = 0;
        check_status("err_cleared");
    endtask

    task automatic test_bad_len();
        logic [7:0] v;
        set_len(0); commit();
        check_status("len0_rejected");
        set_len(257); commit();
        check_status("len257_rejected");
        reg_read(QBC_LEN_HI, v);
        n_checks++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL len_hi_read: got %02h expected 01", v);
        end
        reg_read(QBC_CTRL, v);
        n_checks++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL ctrl_read: got %02h expected 00", v);
        end
        reg_write(QBC_STATUS, 8'hFF);
        m_err = 0;
        check_status("status_write_clears_err");
    endtask

    task automatic test_toggle_full();
        set_len(BB);
        commit();
        run_drain(1, 1);
    endtask

    task automatic test_random();
        int nb, n;
        for (int it = 0; it < 8; it++) begin
            reg_write(QBC_CTRL, 8'h04);
            m_irq = 0;
            n_checks++;
            if (irq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_clr: got %b expected 0", irq_o);
            end
            if ($urandom_range(0, 3) == 0) begin
                set_len($urandom_range(0, 1) ? 0 : $urandom_range(BB + 1, 511));
                commit();
                check_status("rand_bad_commit");
                reg_write(QBC_STATUS, 8'h00);
                m_err = 0;
            end
            nb = $urandom_range(1, 2);
            for (int k = 0; k < nb; k++) begin
                n = ($urandom_range(0, 7) == 0) ? BB : $urandom_range(1, 40);
                set_len(n);
                commit();
            end
            run_drain(2, 0);
        end
    endtask

    task automatic test_abort();
        int cnt;
        logic [7:0] v;
        set_len(8); commit();
        cnt = 0;
        for (int g = 0; g < 20 && cnt < 3; g++) begin
            acc_req_i = 1;
            #1;
            if (acc_rd_o === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        cs = 1; we = 1; addr = QBC_CTRL; data_i = 8'h02;
        #1;
        n_checks++;
        if (cnt !== 3 || acc_rd_o !== 1'b1 || acc_addr_o !== 8'd3) begin
            n_fail++;
            $display("FAIL abort_setup: strobes %0d rd %b addr %0d expected 3 1 3", cnt, acc_rd_o, acc_addr_o);
        end
        @(posedge clk); #1;
        cs = 0; we = 0; acc_req_i = 0;
        m_full = 2'b00; m_cpu = 0; m_acc = 0; m_err = 0;
        n_checks++;
        if (acc_valid_o !== 1'b0 || acc_empty_o !== 1'b1 || cpu_bank_o !== 1'b0 || acc_bank_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: valid %b empty %b cpu %b acc %b expected 0 1 0 0",
                     acc_valid_o, acc_empty_o, cpu_bank_o, acc_bank_o);
        end
        check_status("abort_status");
        reg_read(QBC_LEN_LO, v);
        n_checks++;
        if (v !== 8'h08) begin
            n_fail++;
            $display("FAIL abort_keeps_len: got %02h expected 08", v);
        end
        set_len(3); commit();
        run_drain(0, 1);
    endtask

    task automatic test_reset_mid();
        int cnt;
        set_len(8); commit();
        cnt = 0;
        for (int g = 0; g < 20 && cnt < 2; g++) begin
            acc_req_i = 1;
            #1;
            if (acc_rd_o === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (acc_rd_o !== 1'b0 || acc_valid_o !== 1'b0 || acc_addr_o !== 8'd0 || irq_o !== 1'b0 ||
            cpu_bank_o !== 1'b0 || acc_bank_o !== 1'b0 || acc_empty_o !== 1'b1 || data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: rd %b valid %b addr %0d irq %b cpu %b acc %b empty %b data %02h expected 0 0 0 0 0 0 1 00",
                     acc_rd_o, acc_valid_o, acc_addr_o, irq_o, cpu_bank_o, acc_bank_o, acc_empty_o, data_o);
        end
        acc_req_i = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check_status("status_after_async_reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_len();
        test_toggle_full();
        test_random();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
